// File: rtl/control_fsm_param.sv
// Multi-cycle fetch/execute/memory-wait control unit.
// Tracks call depth, memory-ready timeouts and a sticky error halt.
module control_fsm_param #(
    parameter int OPW        = 4,
    parameter int FSW        = 3,
    parameter int CALL_DEPTH = 4,
    parameter int TIMEOUT    = 15,
    localparam int DW = $clog2(CALL_DEPTH + 1),
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           Z,
    input  logic           mem_ready,
    output logic [1:0]     state,
    output logic [1:0]     NS,
    output logic [1:0]     PS,
    output logic           IL,
    output logic           MB,
    output logic [FSW-1:0] FS,
    output logic           MD,
    output logic           RW,
    output logic           MM,
    output logic           MW,
    output logic           LS,
    output logic [DW-1:0]  depth,
    output logic           halted,
    output logic [1:0]     err
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXEC    = 2'b01,
        S_MEMWAIT = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ST   = 3'b010;
    localparam logic [2:0] OP_BZ   = 3'b011;
    localparam logic [2:0] OP_BNZ  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_JMP  = 2'b10;
    localparam logic [1:0] PS_RET  = 2'b11;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_ILL   = 2'b01;
    localparam logic [1:0] E_STACK = 2'b10;
    localparam logic [1:0] E_TMO   = 2'b11;

    localparam int WW1 = WW + 1;
    localparam logic [WW:0]   TO_LIM    = WW1'(TIMEOUT);
    localparam logic [WW:0]   WAIT_ONE  = WW1'(1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(CALL_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    state_t        cur;
    state_t        nxt;
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [1:0]    err_q;
    logic [1:0]    err_d;
    logic [WW-1:0] wait_q;
    logic [WW-1:0] wait_d;
    logic [WW:0]   wait_inc;
    logic [WW-1:0] wait_sat;
    logic          timeout_hit;
    logic          cls;
    logic          rsv;
    logic [2:0]    sub;

    assign cls = opcode[OPW-1];
    assign sub = opcode[2:0];

    // Count of cycles already spent waiting, plus the current one.
    assign wait_inc    = {1'b0, wait_q} + WAIT_ONE;
    assign wait_sat    = (wait_q == '1) ? wait_q : wait_inc[WW-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (wait_inc >= TO_LIM);

    // Any set bit between the class bit and the sub-op is illegal.
    always_comb begin
        rsv = 1'b0;
        for (int i = 3; i < OPW - 1; i++) begin
            rsv = rsv | opcode[i];
        end
    end

    // Next-state, bookkeeping updates and control decode.
    always_comb begin
        nxt     = cur;
        depth_d = depth_q;
        err_d   = err_q;
        PS      = PS_HOLD;
        IL      = 1'b0;
        MB      = 1'b0;
        FS      = '0;
        MD      = 1'b0;
        RW      = 1'b0;
        MM      = 1'b0;
        MW      = 1'b0;
        LS      = 1'b0;
        unique case (cur)
            S_FETCH: begin
                MM = 1'b1;
                IL = mem_ready;
                if (mem_ready) begin
                    nxt = S_EXEC;
                end else if (timeout_hit) begin
                    nxt   = S_HALT;
                    err_d = E_TMO;
                end
            end
            S_EXEC: begin
                if (!cls) begin
                    FS  = opcode[FSW-1:0];
                    RW  = 1'b1;
                    PS  = PS_INC;
                    nxt = S_FETCH;
                end else if (rsv) begin
                    nxt   = S_HALT;
                    err_d = E_ILL;
                end else begin
                    unique case (sub)
                        OP_LDI: begin
                            MB  = 1'b1;
                            RW  = 1'b1;
                            PS  = PS_INC;
                            nxt = S_FETCH;
                        end
                        OP_LD, OP_ST: begin
                            nxt = S_MEMWAIT;
                        end
                        OP_BZ: begin
                            PS  = Z ? PS_JMP : PS_INC;
                            nxt = S_FETCH;
                        end
                        OP_BNZ: begin
                            PS  = Z ? PS_INC : PS_JMP;
                            nxt = S_FETCH;
                        end
                        OP_CALL: begin
                            if (depth_q == DEPTH_MAX) begin
                                nxt   = S_HALT;
                                err_d = E_STACK;
                            end else begin
                                LS      = 1'b1;
                                PS      = PS_JMP;
                                depth_d = depth_q + DEPTH_ONE;
                                nxt     = S_FETCH;
                            end
                        end
                        OP_JMP: begin
                            PS  = PS_JMP;
                            nxt = S_FETCH;
                        end
                        OP_RET: begin
                            if (depth_q == '0) begin
                                nxt   = S_HALT;
                                err_d = E_STACK;
                            end else begin
                                PS      = PS_RET;
                                depth_d = depth_q - DEPTH_ONE;
                                nxt     = S_FETCH;
                            end
                        end
                        default: nxt = S_HALT;
                    endcase
                end
            end
            S_MEMWAIT: begin
                MD = (sub == OP_LD);
                MW = (sub == OP_ST);
                RW = (sub == OP_LD) && mem_ready;
                if (mem_ready) begin
                    PS  = PS_INC;
                    nxt = S_FETCH;
                end else if (timeout_hit) begin
                    nxt   = S_HALT;
                    err_d = E_TMO;
                end
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: nxt = S_HALT;
        endcase
    end

    // Wait counter clears on any transition and saturates while stalled.
    always_comb begin
        if (nxt != cur) begin
            wait_d = '0;
        end else if ((cur == S_FETCH || cur == S_MEMWAIT) && !mem_ready) begin
            wait_d = wait_sat;
        end else begin
            wait_d = wait_q;
        end
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            depth_q <= '0;
            err_q   <= E_NONE;
            wait_q  <= '0;
        end else begin
            cur     <= nxt;
            depth_q <= depth_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign state  = cur;
    assign NS     = nxt;
    assign depth  = depth_q;
    assign err    = err_q;
    assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_control_fsm_param.sv
// Scoreboard bench for control_fsm_param: a transaction-level model
// queues per-cycle expectations, a negedge monitor compares them.
module tb_control_fsm_param;

    localparam int OPW = 6;
    localparam int FSW = 3;
    localparam int CD  = 4;
    localparam int TO  = 15;
    localparam int DW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opcode;
    logic           Z;
    logic           mem_ready;
    logic [1:0]     state;
    logic [1:0]     NS;
    logic [1:0]     PS;
    logic           IL;
    logic           MB;
    logic [FSW-1:0] FS;
    logic           MD;
    logic           RW;
    logic           MM;
    logic           MW;
    logic           LS;
    logic [DW-1:0]  depth;
    logic           halted;
    logic [1:0]     err;

    control_fsm_param #(
        .OPW(OPW), .FSW(FSW), .CALL_DEPTH(CD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .Z(Z),
        .mem_ready(mem_ready), .state(state), .NS(NS), .PS(PS),
        .IL(IL), .MB(MB), .FS(FS), .MD(MD), .RW(RW), .MM(MM),
        .MW(MW), .LS(LS), .depth(depth), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    state;
        logic [1:0]    ns;
        logic [1:0]    ps;
        logic          il;
        logic          mb;
        logic [2:0]    fs;
        logic          md;
        logic          rw;
        logic          mm;
        logic          mw;
        logic          ls;
        logic [DW-1:0] depth;
        logic          halted;
        logic [1:0]    err;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   chk;
        int   tag;
    } item_t;

    item_t sbq[$];
    int    errors = 0;
    int    checks = 0;

    // Architectural model: call depth, error code, halted flag.
    int m_depth = 0;
    int m_err   = 0;
    bit m_halted = 1'b0;

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [OPW-1:0] rop();
        return OPW'($urandom);
    endfunction

    function automatic obs_t blank(input logic [1:0] st);
        obs_t o;
        o        = '0;
        o.state  = st;
        o.ns     = st;
        o.depth  = m_depth[DW-1:0];
        o.err    = m_err[1:0];
        o.halted = (st == 2'd3);
        return o;
    endfunction

    task automatic step(input logic r, input logic [OPW-1:0] op,
                        input logic z, input logic mr,
                        input obs_t e, input bit chk, input int tag);
        item_t it;
        rst       = r;
        opcode    = op;
        Z         = z;
        mem_ready = mr;
        it.v      = e;
        it.chk    = chk;
        it.tag    = tag;
        sbq.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, rop(), rz(), rz(), '0, 1'b0, -1);
        m_depth  = 0;
        m_err    = 0;
        m_halted = 1'b0;
    endtask

    task automatic halt_cycle(input int tag);
        step(1'b0, rop(), rz(), rz(), blank(2'd3), 1'b1, tag);
    endtask

    // Fetch stall of n cycles with memory never ready.
    task automatic fetch_stall(input int n, input int tag);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e    = blank(2'd0);
            e.mm = 1'b1;
            step(1'b0, rop(), rz(), 1'b0, e, 1'b1, tag);
        end
    endtask

    // One instruction: fetch latency, execute, optional memory latency.
    task automatic run_instr(input logic [OPW-1:0] op, input logic z,
                             input int flat, input int mlat,
                             input int tag);
        obs_t       e;
        logic       mr;
        logic       cls;
        logic       rsv;
        logic [2:0] sub;
        int         dd;
        int         ne;
        if (m_halted) begin
            halt_cycle(tag);
            return;
        end
        for (int i = 0; i <= flat; i++) begin
            mr   = (i == flat);
            e    = blank(2'd0);
            e.mm = 1'b1;
            e.il = mr;
            if (mr) e.ns = 2'd1;
            else if (i + 1 >= TO) e.ns = 2'd3;
            step(1'b0, rop(), rz(), mr, e, 1'b1, tag);
            if (!mr && i + 1 >= TO) begin
                m_err    = 3;
                m_halted = 1'b1;
                return;
            end
        end
        cls  = op[OPW-1];
        rsv  = (op[OPW-2:3] != '0);
        sub  = op[2:0];
        dd   = 0;
        ne   = 0;
        e    = blank(2'd1);
        e.ns = 2'd0;
        if (!cls) begin
            e.fs = op[2:0];
            e.rw = 1'b1;
            e.ps = 2'd1;
        end else if (rsv) begin
            e.ns = 2'd3;
            ne   = 1;
        end else begin
            case (sub)
                3'd0: begin e.mb = 1'b1; e.rw = 1'b1; e.ps = 2'd1; end
                3'd1, 3'd2: e.ns = 2'd2;
                3'd3: e.ps = z ? 2'd2 : 2'd1;
                3'd4: e.ps = z ? 2'd1 : 2'd2;
                3'd5: begin
                    if (m_depth == CD) begin
                        e.ns = 2'd3;
                        ne   = 2;
                    end else begin
                        e.ls = 1'b1;
                        e.ps = 2'd2;
                        dd   = 1;
                    end
                end
                3'd6: e.ps = 2'd2;
                default: begin
                    if (m_depth == 0) begin
                        e.ns = 2'd3;
                        ne   = 2;
                    end else begin
                        e.ps = 2'd3;
                        dd   = -1;
                    end
                end
            endcase
        end
        step(1'b0, op, z, rz(), e, 1'b1, tag);
        m_depth = m_depth + dd;
        if (e.ns == 2'd3) begin
            m_err    = ne;
            m_halted = 1'b1;
            return;
        end
        if (e.ns != 2'd2) return;
        for (int i = 0; i <= mlat; i++) begin
            mr   = (i == mlat);
            e    = blank(2'd2);
            e.md = (sub == 3'd1);
            e.mw = (sub == 3'd2);
            e.rw = (sub == 3'd1) && mr;
            if (mr) begin
                e.ps = 2'd1;
                e.ns = 2'd0;
            end else if (i + 1 >= TO) begin
                e.ns = 2'd3;
            end
            step(1'b0, op, rz(), mr, e, 1'b1, tag);
            if (!mr && i + 1 >= TO) begin
                m_err    = 3;
                m_halted = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; pop and compare.
    always @(negedge clk) begin : mon
        item_t it;
        obs_t  a;
        if (sbq.size() != 0) begin
            it = sbq.pop_front();
            if (it.chk) begin
                a.state  = state;
                a.ns     = NS;
                a.ps     = PS;
                a.il     = IL;
                a.mb     = MB;
                a.fs     = FS;
                a.md     = MD;
                a.rw     = RW;
                a.mm     = MM;
                a.mw     = MW;
                a.ls     = LS;
                a.depth  = depth;
                a.halted = halted;
                a.err    = err;
                checks++;
                if (a !== it.v) begin
                    errors++;
                    $display("FAIL outputs tag=%0d t=%0t got=%p expected=%p",
                             it.tag, $time, a, it.v);
                end
            end
        end
    end

    initial begin
        logic [OPW-1:0] op;
        int             p;
        int             fl;
        int             ml;
        int             n;
        rst       = 1'b1;
        opcode    = '0;
        Z         = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // ALU op after reset, first fetch cycle with memory not ready.
        do_reset();
        run_instr(6'b000101, 1'b0, 1, 0, 1);
        // LD with three stall cycles in MEMWAIT.
        run_instr(6'b100001, 1'b0, 0, 3, 2);
        // Branches.
        run_instr(6'b100011, 1'b1, 0, 0, 3);
        run_instr(6'b100011, 1'b0, 0, 0, 4);
        run_instr(6'b100100, 1'b1, 0, 0, 5);
        run_instr(6'b100100, 1'b0, 2, 0, 6);
        run_instr(6'b100000, 1'b0, 0, 0, 7);
        run_instr(6'b100010, 1'b0, 0, 2, 8);
        // Call overflow on the fifth nested call.
        for (int i = 0; i < 5; i++) run_instr(6'b100101, 1'b0, 0, 0, 10 + i);
        halt_cycle(15);
        do_reset();
        // Return underflow.
        run_instr(6'b100111, 1'b0, 0, 0, 16);
        halt_cycle(17);
        do_reset();
        // Fetch timeout; a latency of 14 just misses it.
        run_instr(6'b000011, 1'b0, 14, 0, 18);
        run_instr(6'b000011, 1'b0, 20, 0, 19);
        halt_cycle(20);
        halt_cycle(21);
        do_reset();
        // Reset in the middle of a fetch stall.
        fetch_stall(6, 22);
        do_reset();
        run_instr(6'b000110, 1'b1, 0, 0, 23);
        // Illegal opcode then JMP.
        run_instr(6'b101000, 1'b0, 0, 0, 24);
        halt_cycle(25);
        do_reset();
        run_instr(6'b100110, 1'b0, 0, 0, 26);
        // Store timing out in MEMWAIT.
        run_instr(6'b100010, 1'b0, 0, 20, 27);
        halt_cycle(28);
        do_reset();

        // Randomised instruction stream.
        for (n = 100; n < 500; n++) begin
            if (m_halted) begin
                halt_cycle(n);
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            op = rop();
            p  = $urandom_range(0, 99);
            if (p < 25) begin
                op[OPW-1] = 1'b0;
            end else if (p < 30) begin
                op[OPW-1] = 1'b1;
                if (op[OPW-2:3] == '0) op[3] = 1'b1;
            end else begin
                op[OPW-1]   = 1'b1;
                op[OPW-2:3] = '0;
            end
            fl = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17)
                                             : $urandom_range(0, 3);
            ml = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17)
                                             : $urandom_range(0, 3);
            run_instr(op, rz(), fl, ml, n);
        end

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_fsm_param.md
Name: control_fsm_param

Overview:
- Multi-cycle sequential control unit for the datapath: fetch → execute → optional memory wait, with an explicit registered state.
- Generalised opcode width, ALU function-select width, call-depth tracking, memory-ready handshake with timeout, and sticky halt on error.
- Sits between the instruction register (opcode), the ALU zero flag (Z), the memory interface (mem_ready) and the PC/register file/memory control pins.

Parameters:
- OPW, 4, opcode width (≥4); class bit = opcode[OPW-1]; sub-op = opcode[2:0]
- FSW, 3, ALU function-select width, FS = opcode[FSW-1:0]; must satisfy FSW ≤ OPW-1
- CALL_DEPTH, 4, max nested calls tracked (≥1)
- TIMEOUT, 15, max consecutive mem_ready-low cycles in a wait state; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPW  current instruction opcode
- Z  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- state  out  2  current state: 00 FETCH, 01 EXEC, 10 MEMWAIT, 11 HALT
- NS  out  2  next state (combinational)
- PS  out  2  PC select: 00 hold, 01 increment, 10 jump/branch, 11 return
- IL  out  1  instruction load
- MB  out  1  B-operand mux: immediate
- FS  out  FSW  ALU function select
- MD  out  1  register write-data mux: memory
- RW  out  1  register write enable
- MM  out  1  memory address mux: PC
- MW  out  1  memory write
- LS  out  1  link save (push PC) strobe
- depth  out  clog2(CALL_DEPTH+1)  current call depth
- halted  out  1  in HALT
- err  out  2  00 none, 01 illegal opcode, 10 call over/underflow, 11 memory timeout

Behaviour:
- Registers: state, depth, err, wait_cnt. All other outputs are combinational from state/opcode/Z/mem_ready/wait_cnt.
- Default for every control output is 0 unless listed below.
- Reset (rst=1 at a clk edge), takes priority mid-operation: state=FETCH, depth=0, err=00, wait_cnt=0. Post-reset outputs are the FETCH values with mem_ready=0: MM=1, everything else 0.
- FETCH: MM=1, IL=mem_ready.
  - mem_ready=1 → EXEC, wait_cnt=0.
  - Otherwise wait_cnt++; when wait_cnt reaches TIMEOUT (TIMEOUT≠0) → HALT with err=11.
- EXEC, opcode[OPW-1]=0 (ALU op): FS=opcode[FSW-1:0], RW=1, PS=01 → FETCH.
- EXEC, opcode[OPW-1]=1: any nonzero bit in opcode[OPW-2:3] → HALT, err=01, no side effects. Otherwise decode sub-op:
  - 000 LDI: MB=1, RW=1, PS=01 → FETCH
  - 001 LD: → MEMWAIT, PS=00
  - 010 ST: → MEMWAIT, PS=00
  - 011 BZ: PS = Z ? 10 : 01 → FETCH
  - 100 BNZ: PS = Z ? 01 : 10 → FETCH
  - 101 CALL: if depth==CALL_DEPTH → HALT, err=10, LS=0, PS=00; else LS=1, PS=10, depth++ → FETCH
  - 110 JMP: PS=10 → FETCH
  - 111 RET: if depth==0 → HALT, err=10, PS=00; else PS=11, depth-- → FETCH
- MEMWAIT: opcode is held stable by the IR; MM=0.
  - LD: MD=1; RW=mem_ready.
  - ST: MW=1.
  - mem_ready=1 → PS=01 → FETCH, wait_cnt=0.
  - Otherwise PS=00, wait_cnt++; timeout rule as in FETCH → HALT, err=11.
- wait_cnt clears on every state change. It saturates and never wraps.
- HALT: all control outputs 0, PS=00, halted=1. err and depth are frozen. The only exit is rst.
- A mem_ready pulse outside FETCH/MEMWAIT is ignored.
- NS always equals the value state takes at the next edge when rst=0.

Test Plan:
- Reset, then mem_ready=1 with opcode=0101 → state 00→01→00; EXEC cycle shows FS=101, RW=1, PS=01; reset cycle outputs MM=1, all else 0.
- LD (1001) with mem_ready low 3 cycles then high → MEMWAIT lasts 4 cycles, MD=1 throughout; RW=1 and PS=01 only in the last cycle; PS=00 before that.
- BZ with Z=1 → PS=10; BZ with Z=0 → PS=01; BNZ with Z=1 → PS=01.
- CALL_DEPTH=4: five CALLs → depth 1..4 with LS=1 on each accepted call; the fifth gives HALT, err=10, LS=0. After reset, a RET at depth=0 → HALT, err=10.
- TIMEOUT=15: hold mem_ready=0 in FETCH → HALT on the 15th wait cycle, err=11, halted=1. Asserting rst mid-wait → FETCH next edge, err=00.
- OPW=6: opcode 101000 → HALT with err=01; opcode 100110 (JMP) → PS=10.
